unary_add_ctrl: RTL and testbench

Sequencer and collector for the unary adder datapath. Accepts two binary operands over a valid/ready handshake and serialises them into the adder's unary `A`/`B` streams during a read phase. It then switches the adder into its write phase, counts the `dout` ones back into a binary sum and captures the carry. Sits on both sides of the adder: it drives `A`, `B`, `en` and `read_or_write`, and consumes `dout` and `C`.

---
 rtl/unary_add_pkg.sv | 18 +
 rtl/unary_add_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_unary_add_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_add_pkg.sv
// ---------------------------------------------------------------------------
// unary_add_pkg
// Shared definitions for the unary adder controller and its surroundings.
//   ua_state_t    : controller FSM state encoding (IDLE/READ/WRITE/DONE)
//   UA_W_DEFAULT  : default operand / sum / adder counter width
// ---------------------------------------------------------------------------
package unary_add_pkg;

    localparam int UA_W_DEFAULT = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ua_state_t;

endpackage : unary_add_pkg

// File: rtl/unary_add_ctrl.sv
// ---------------------------------------------------------------------------
// unary_add_ctrl
// Sequencer and collector wrapped around the unary adder datapath. Takes a
// binary operand pair over valid/ready, streams both operands into the
// adder as unary pulse trains (read phase), then flips the adder into its
// write phase and counts the returned dout ones back into a binary sum.
// Adder overflow pulses on C are OR-ed into a sticky carry.
//
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   in_valid, in_ready   operand handshake (in_ready high only in IDLE)
//   a_bin, b_bin         W-bit operands, captured on accept
//   A, B                 unary streams to the adder
//   en, read_or_write    adder enable, phase select (0 read, 1 write)
//   dout, C              adder serial output and overflow pulse
//   out_valid, out_ready result handshake (held until accepted)
//   sum_bin, carry       (a+b) mod 2^W and overflow flag
//   chk_err              binary self-check mismatch flag
//
// Build option:
//   UNARY_ADD_SELFCHECK_EN  when defined, a binary reference adder checks
//                           every result; otherwise chk_err is tied low.
// ---------------------------------------------------------------------------
module unary_add_ctrl
    import unary_add_pkg::*;
#(
    parameter int W = UA_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_bin,
    input  logic [W-1:0] b_bin,
    output logic         A,
    output logic         B,
    output logic         en,
    output logic         read_or_write,
    input  logic         dout,
    input  logic         C,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum_bin,
    output logic         carry,
    output logic         chk_err
);

    ua_state_t    state_q, state_d;
    logic [W-1:0] aOp_q, aOp_d;
    logic [W-1:0] bOp_q, bOp_d;
    logic [W-1:0] len_q, len_d;
    logic [W-1:0] rdCnt_q, rdCnt_d;
    logic [W-1:0] ones_q, ones_d;
    logic         carry_q, carry_d;
    logic         firstWrite_q, firstWrite_d;
    logic [W-1:0] acceptLen;

    // Read length is the longer operand, but never zero: a 0+0 request
    // still needs one read cycle so the adder sees a well-formed phase.
    always_comb begin
        acceptLen = (a_bin > b_bin) ? a_bin : b_bin;
        if (acceptLen == '0) begin
            acceptLen = W'(1);
        end
    end

    // Main sequencer: next-state and register updates for the operation.
    // The first WRITE cycle only samples C (the overflow of the final read
    // cycle arrives one cycle late); dout is counted from the second on.
    always_comb begin
        state_d      = state_q;
        aOp_d        = aOp_q;
        bOp_d        = bOp_q;
        len_d        = len_q;
        rdCnt_d      = rdCnt_q;
        ones_d       = ones_q;
        carry_d      = carry_q;
        firstWrite_d = firstWrite_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    aOp_d   = a_bin;
                    bOp_d   = b_bin;
                    len_d   = acceptLen;
                    rdCnt_d = '0;
                    ones_d  = '0;
                    carry_d = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                carry_d = carry_q | C;
                rdCnt_d = rdCnt_q + W'(1);
                if (rdCnt_q == len_q - W'(1)) begin
                    firstWrite_d = 1'b1;
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                if (firstWrite_q) begin
                    carry_d      = carry_q | C;
                    firstWrite_d = 1'b0;
                end else if (dout) begin
                    ones_d = ones_q + W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            aOp_q        <= '0;
            bOp_q        <= '0;
            len_q        <= '0;
            rdCnt_q      <= '0;
            ones_q       <= '0;
            carry_q      <= 1'b0;
            firstWrite_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            aOp_q        <= aOp_d;
            bOp_q        <= bOp_d;
            len_q        <= len_d;
            rdCnt_q      <= rdCnt_d;
            ones_q       <= ones_d;
            carry_q      <= carry_d;
            firstWrite_q <= firstWrite_d;
        end
    end

    // Moore outputs. in_ready is masked by rst so nothing is accepted while
    // the adder is still being held in reset.
    always_comb begin
        in_ready      = (state_q == IDLE) && !rst;
        A             = (state_q == READ) && (rdCnt_q < aOp_q);
        B             = (state_q == READ) && (rdCnt_q < bOp_q);
        en            = (state_q == READ) || (state_q == WRITE);
        read_or_write = (state_q == WRITE);
        out_valid     = (state_q == DONE);
        sum_bin       = (state_q == DONE) ? ones_q : '0;
        carry         = carry_q;
    end

`ifdef UNARY_ADD_SELFCHECK_EN
    logic [W:0] ref_q, ref_d;
    logic       chkErr_q, chkErr_d;

    // Binary reference captured on accept; compared once, on the edge that
    // enters DONE, when ones_q and carry_q hold their final values.
    always_comb begin
        ref_d    = ref_q;
        chkErr_d = chkErr_q;
        if (state_q == IDLE && in_valid) begin
            ref_d    = {1'b0, a_bin} + {1'b0, b_bin};
            chkErr_d = 1'b0;
        end else if (state_q == WRITE && !firstWrite_q && !dout) begin
            chkErr_d = (ones_q != ref_q[W-1:0]) || (carry_q != ref_q[W]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q    <= '0;
            chkErr_q <= 1'b0;
        end else begin
            ref_q    <= ref_d;
            chkErr_q <= chkErr_d;
        end
    end

    assign chk_err = chkErr_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule : unary_add_ctrl

// File: tb/tb_unary_add_ctrl.sv
// Self-checking bench for unary_add_ctrl. The unary adder is represented by
// a small behavioural model: it counts A+B per read cycle mod 2^W with a
// registered one-cycle overflow pulse on C, and in the write phase emits
// one registered dout pulse per stored count.
module tb_unary_add_ctrl;
    import unary_add_pkg::*;

    localparam int W = UA_W_DEFAULT;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_bin;
    logic [W-1:0] b_bin;
    logic         A;
    logic         B;
    logic         en;
    logic         read_or_write;
    logic         dout;
    logic         C;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_bin;
    logic         carry;
    logic         chk_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int sum;
        int cy;
        int lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    unary_add_ctrl #(.W(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_bin         (a_bin),
        .b_bin         (b_bin),
        .A             (A),
        .B             (B),
        .en            (en),
        .read_or_write (read_or_write),
        .dout          (dout),
        .C             (C),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .sum_bin       (sum_bin),
        .carry         (carry),
        .chk_err       (chk_err)
    );

    // Behavioural unary adder, reset together with the controller.
    logic [W-1:0] accQ;
    logic         doutQ;
    logic         cQ;
    logic [W:0]   accNext;

    assign accNext = {1'b0, accQ} + (W+1)'(A) + (W+1)'(B);
    assign dout    = doutQ;
    assign C       = cQ;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            accQ  <= '0;
            doutQ <= 1'b0;
            cQ    <= 1'b0;
        end else if (en && !read_or_write) begin
            accQ  <= accNext[W-1:0];
            cQ    <= accNext[W];
            doutQ <= 1'b0;
        end else if (en && read_or_write) begin
            cQ    <= 1'b0;
            doutQ <= (accQ != '0);
            if (accQ != '0) accQ <= accQ - W'(1);
        end else begin
            cQ    <= 1'b0;
            doutQ <= 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation end to end: accept, stream monitoring, optional
    // out_ready back-pressure, then scoreboard comparison and release.
    task automatic applyStimulus(input int aIn, input int bIn, input int holdLow);
        int   n;
        int   lenExp;
        int   rdCnt;
        int   wrCnt;
        int   aCnt;
        int   bCnt;
        int   lat;
        bit   readySeen;
        bit   validDrop;
        exp_t e;
        exp_t got;

        n = 0;
        while (!in_ready && n < 20000) begin
            step();
            n++;
        end
        checkOutput("in_ready_wait", int'(in_ready), 1);

        lenExp = (aIn > bIn) ? aIn : bIn;
        if (lenExp == 0) lenExp = 1;
        e.sum = (aIn + bIn) % (1 << W);
        e.cy  = ((aIn + bIn) >= (1 << W)) ? 1 : 0;
        e.lat = 1 + lenExp + e.sum + 2;
        sb.push_back(e);

        a_bin    = W'(aIn);
        b_bin    = W'(bIn);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;

        lat = 1; rdCnt = 0; wrCnt = 0; aCnt = 0; bCnt = 0; readySeen = 1'b0;
        while (!out_valid && lat < 20000) begin
            if (en && !read_or_write) begin
                rdCnt++;
                aCnt += int'(A);
                bCnt += int'(B);
            end
            if (en && read_or_write) wrCnt++;
            if (in_ready) readySeen = 1'b1;
            step();
            lat++;
        end
        checkOutput("out_valid_wait", int'(out_valid), 1);

        got.sum = int'(sum_bin);
        got.cy  = int'(carry);
        got.lat = lat;
        e = sb.pop_front();
        checkOutput("latency", got.lat, e.lat);
        checkOutput("read_cycles", rdCnt, lenExp);
        checkOutput("a_pulses", aCnt, aIn);
        checkOutput("b_pulses", bCnt, bIn);
        checkOutput("write_cycles", wrCnt, e.sum + 2);
        checkOutput("in_ready_busy", int'(readySeen), 0);

        validDrop = 1'b0;
        for (int i = 0; i < holdLow; i++) begin
            step();
            if (!out_valid || in_ready || en) validDrop = 1'b1;
        end
        if (holdLow > 0) checkOutput("done_hold", int'(validDrop), 0);

        checkOutput("sum_bin", int'(sum_bin), e.sum);
        checkOutput("carry", int'(carry), e.cy);
        checkOutput("chk_err", int'(chk_err), 0);

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checkOutput("out_valid_release", int'(out_valid), 0);
        checkOutput("in_ready_release", int'(in_ready), 1);
    endtask

    initial begin
        int  n;
        bit  chkSeen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_bin     = '0;
        b_bin     = '0;

        step();
        step();
        checkOutput("rst_en", int'(en), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_sum", int'(sum_bin), 0);
        checkOutput("rst_carry", int'(carry), 0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", int'(in_ready), 1);

        $display("[TB] 3+4");
        applyStimulus(3, 4, 0);
        $display("[TB] 0+0");
        applyStimulus(0, 0, 0);
        $display("[TB] 8191+1");
        applyStimulus(8191, 1, 0);
        $display("[TB] 8000+500");
        applyStimulus(8000, 500, 0);
        $display("[TB] back-to-back 5+6 (held), 1+1");
        applyStimulus(5, 6, 10);
        applyStimulus(1, 1, 0);

        // Abort 100+100 part-way through WRITE with an async reset.
        $display("[TB] reset mid-WRITE");
        chkSeen  = 1'b0;
        a_bin    = W'(100);
        b_bin    = W'(100);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!read_or_write && n < 1000) begin
            if (chk_err) chkSeen = 1'b1;
            step();
            n++;
        end
        checkOutput("reach_write", int'(read_or_write), 1);
        for (int i = 0; i < 20; i++) begin
            if (chk_err) chkSeen = 1'b1;
            step();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_A", int'(A), 0);
        checkOutput("mid_rst_B", int'(B), 0);
        checkOutput("mid_rst_en", int'(en), 0);
        checkOutput("mid_rst_row", int'(read_or_write), 0);
        checkOutput("mid_rst_out_valid", int'(out_valid), 0);
        checkOutput("mid_rst_carry", int'(carry), 0);
        checkOutput("mid_rst_chk_err", int'(chk_err), 0);
        checkOutput("mid_rst_sum", int'(sum_bin), 0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", int'(in_ready), 1);
        checkOutput("chk_err_abort", int'(chkSeen), 0);
        applyStimulus(2, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_unary_add_ctrl
